// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one single-precision multiplier among N requesters, one operation in flight.
// Optional macro FPMUL_ARB_TIMEOUT_EN adds a WAIT_Z timeout that returns a quiet NaN and sets a sticky err.

module fp_mul_arbiter #(
   parameter int N       = 4,
   parameter int IDW     = 2,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [32*N-1:0]   req_a,
   input  logic [32*N-1:0]   req_b,
   input  logic [N-1:0]      req_stb,
   output logic [N-1:0]      req_ack,
   output logic [31:0]       resp_z,
   output logic [N-1:0]      resp_stb,
   input  logic [N-1:0]      resp_ack,
   output logic [31:0]       mul_a,
   output logic              mul_a_stb,
   input  logic              mul_a_ack,
   output logic [31:0]       mul_b,
   output logic              mul_b_stb,
   input  logic              mul_b_ack,
   input  logic [31:0]       mul_z,
   input  logic              mul_z_stb,
   output logic              mul_z_ack,
   output logic              busy,
   output logic              err
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ACCEPT = 3'd1;
   localparam logic [2:0] S_SEND_A = 3'd2;
   localparam logic [2:0] S_SEND_B = 3'd3;
   localparam logic [2:0] S_WAIT_Z = 3'd4;
   localparam logic [2:0] S_PUT_Z  = 3'd5;

   if (N < 2 || IDW != $clog2(N) || TIMEOUT < 1) begin : g_paramCheck
      $error("fp_mul_arbiter: inconsistent parameters");
   end

   logic [2:0]     r_state;
   logic [IDW-1:0] r_ptr;
   logic [IDW-1:0] r_gnt;
   logic [31:0]    r_opA;
   logic [31:0]    r_opB;
   logic [31:0]    r_z;
   logic [N-1:0]   r_reqAck;
   logic [31:0]    r_respZ;
   logic [N-1:0]   r_respStb;
   logic [31:0]    r_mulA;
   logic           r_mulAStb;
   logic [31:0]    r_mulB;
   logic           r_mulBStb;
   logic           r_mulZAck;

   logic           w_found;
   logic [IDW-1:0] w_next;
   logic [IDW-1:0] w_ptrNext;
   logic           w_blocked;

`ifdef FPMUL_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0]  r_count;
   logic           r_err;
   assign w_blocked = r_err;
`else
   assign w_blocked = 1'b0;
`endif

   // Lane index at a given offset from the rotating pointer, wrapping past N-1 back to 0.
   function automatic logic [IDW-1:0] wrapIdx(input logic [IDW-1:0] base, input int offset);
      int sum;
      sum = int'(base) + offset;
      if (sum >= N) sum = sum - N;
      return IDW'(sum);
   endfunction

   // Scanning from the far end means the lane closest to r_ptr is the last write and wins.
   always_comb begin
      w_found = 1'b0;
      w_next  = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req_stb[wrapIdx(r_ptr, k)]) begin
            w_found = 1'b1;
            w_next  = wrapIdx(r_ptr, k);
         end
      end
   end

   assign w_ptrNext = (r_gnt == IDW'(N - 1)) ? '0 : r_gnt + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_ptr     <= '0;
         r_gnt     <= '0;
         r_opA     <= '0;
         r_opB     <= '0;
         r_z       <= '0;
         r_reqAck  <= '0;
         r_respZ   <= '0;
         r_respStb <= '0;
         r_mulA    <= '0;
         r_mulAStb <= 1'b0;
         r_mulB    <= '0;
         r_mulBStb <= 1'b0;
         r_mulZAck <= 1'b0;
`ifdef FPMUL_ARB_TIMEOUT_EN
         r_count   <= '0;
         r_err     <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found && !w_blocked) begin
                  r_gnt   <= w_next;
                  r_state <= S_ACCEPT;
               end
            end
            // A withdrawn request abandons the grant without moving the pointer.
            S_ACCEPT: begin
               if (!req_stb[r_gnt]) begin
                  r_reqAck <= '0;
                  r_state  <= S_IDLE;
               end else if (r_reqAck[r_gnt]) begin
                  r_opA    <= req_a[32*r_gnt +: 32];
                  r_opB    <= req_b[32*r_gnt +: 32];
                  r_reqAck <= '0;
                  r_state  <= S_SEND_A;
               end else begin
                  r_reqAck[r_gnt] <= 1'b1;
               end
            end
            S_SEND_A: begin
               if (r_mulAStb && mul_a_ack) begin
                  r_mulAStb <= 1'b0;
                  r_state   <= S_SEND_B;
               end else begin
                  r_mulA    <= r_opA;
                  r_mulAStb <= 1'b1;
               end
            end
            S_SEND_B: begin
               if (r_mulBStb && mul_b_ack) begin
                  r_mulBStb <= 1'b0;
                  r_state   <= S_WAIT_Z;
`ifdef FPMUL_ARB_TIMEOUT_EN
                  r_count   <= '0;
`endif
               end else begin
                  r_mulB    <= r_opB;
                  r_mulBStb <= 1'b1;
               end
            end
            S_WAIT_Z: begin
               if (r_mulZAck && mul_z_stb) begin
                  r_z       <= mul_z;
                  r_mulZAck <= 1'b0;
                  r_state   <= S_PUT_Z;
               end
`ifdef FPMUL_ARB_TIMEOUT_EN
               else if (r_count == CW'(TIMEOUT - 1)) begin
                  r_z       <= 32'hFFC0_0000;
                  r_err     <= 1'b1;
                  r_mulZAck <= 1'b0;
                  r_state   <= S_PUT_Z;
               end else begin
                  r_count   <= r_count + 1'b1;
                  r_mulZAck <= 1'b1;
               end
`else
               else begin
                  r_mulZAck <= 1'b1;
               end
`endif
            end
            // The served lane drops to lowest priority once its result is taken.
            S_PUT_Z: begin
               if (r_respStb[r_gnt] && resp_ack[r_gnt]) begin
                  r_respStb <= '0;
                  r_ptr     <= w_ptrNext;
                  r_state   <= S_IDLE;
               end else begin
                  r_respZ          <= r_z;
                  r_respStb[r_gnt] <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ack   = r_reqAck;
   assign resp_z    = r_respZ;
   assign resp_stb  = r_respStb;
   assign mul_a     = r_mulA;
   assign mul_a_stb = r_mulAStb;
   assign mul_b     = r_mulB;
   assign mul_b_stb = r_mulBStb;
   assign mul_z_ack = r_mulZAck;
   assign busy      = (r_state != S_IDLE);
`ifdef FPMUL_ARB_TIMEOUT_EN
   assign err       = r_err;
`else
   assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: per-lane requesters, a behavioural multiplier stub and a response scoreboard.
// Inputs change #1 after posedge; DUT outputs are observed on negedge.

module tb_fp_mul_arbiter;

   localparam int N       = 4;
   localparam int IDW     = 2;
   localparam int TIMEOUT = 16;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] z;
   } op_t;

   typedef struct {
      int          lane;
      logic [31:0] z;
   } exp_t;

   typedef struct {
      int          lane;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] z;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst;
   logic [32*N-1:0]   reqA;
   logic [32*N-1:0]   reqB;
   logic [N-1:0]      reqStb;
   logic [N-1:0]      reqAck;
   logic [31:0]       respZ;
   logic [N-1:0]      respStb;
   logic [N-1:0]      respAck;
   logic [31:0]       mulA;
   logic              mulAStb;
   logic              mulAAck;
   logic [31:0]       mulB;
   logic              mulBStb;
   logic              mulBAck;
   logic [31:0]       mulZ;
   logic              mulZStb;
   logic              mulZAck;
   logic              busy;
   logic              err;

   op_t         laneQ[N][$];
   exp_t        sb[$];
   int          servedLanes[$];
   vec_t        vecs[6];
   logic [N-1:0] reqDone;
   logic        holdAck;
   logic        stubHoldZ;
   int          total = 0;
   int          bad = 0;
   int          servedCount = 0;
   int          acceptCount = 0;
   op_t         accOp;
   exp_t        expE;

   always #5 clk = ~clk;

   assign respAck = holdAck ? '0 : '1;

   fp_mul_arbiter #(.N(N), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .req_a(reqA), .req_b(reqB), .req_stb(reqStb), .req_ack(reqAck),
      .resp_z(respZ), .resp_stb(respStb), .resp_ack(respAck),
      .mul_a(mulA), .mul_a_stb(mulAStb), .mul_a_ack(mulAAck),
      .mul_b(mulB), .mul_b_stb(mulBStb), .mul_b_ack(mulBAck),
      .mul_z(mulZ), .mul_z_stb(mulZStb), .mul_z_ack(mulZAck),
      .busy(busy), .err(err)
   );

   // Single-precision <-> real conversion for normal numbers and zero.
   function automatic real sp2real(input logic [31:0] x);
      logic [63:0] d;
      if (x[30:0] == 31'd0) d = {x[31], 63'd0};
      else d = {x[31], {3'b000, x[30:23]} + 11'd896, x[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] real2sp(input real r);
      logic [63:0] d;
      logic [10:0] e;
      d = $realtobits(r);
      e = d[62:52] - 11'd896;
      if (d[62:0] == 63'd0) return {d[63], 31'd0};
      return {d[63], e[7:0], d[51:29]};
   endfunction

   // Multiplier stub: a-then-b input handshakes, a b-side ack delay, fixed compute latency.
   int          stubSt;
   int          stubCnt;
   logic [31:0] stubA;
   logic [31:0] stubB;

   always @(posedge clk) begin
      if (rst) begin
         stubSt  <= 0;
         stubCnt <= 0;
         mulAAck <= 1'b0;
         mulBAck <= 1'b0;
         mulZStb <= 1'b0;
         mulZ    <= '0;
      end else begin
         case (stubSt)
            0: begin
               if (mulAAck && mulAStb) begin
                  stubA   <= mulA;
                  mulAAck <= 1'b0;
                  stubCnt <= 0;
                  stubSt  <= 1;
               end else mulAAck <= 1'b1;
            end
            1: begin
               if (mulBAck && mulBStb) begin
                  stubB   <= mulB;
                  mulBAck <= 1'b0;
                  stubCnt <= 0;
                  stubSt  <= 2;
               end else if (stubCnt >= 3) mulBAck <= 1'b1;
               else stubCnt <= stubCnt + 1;
            end
            2: begin
               if (stubCnt >= 3 && !stubHoldZ) begin
                  mulZ    <= real2sp(sp2real(stubA) * sp2real(stubB));
                  mulZStb <= 1'b1;
                  stubSt  <= 3;
               end else stubCnt <= stubCnt + 1;
            end
            default: begin
               if (mulZStb && mulZAck) begin
                  mulZStb <= 1'b0;
                  stubSt  <= 0;
               end
            end
         endcase
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Requester side: present the head of each lane queue, drop the strobe after the accepting edge.
   always begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (rst) begin
            reqStb[i]  = 1'b0;
            reqDone[i] = 1'b0;
         end else begin
            if (reqDone[i]) begin
               reqStb[i]  = 1'b0;
               reqDone[i] = 1'b0;
            end
            if (!reqStb[i] && laneQ[i].size() > 0) begin
               reqA[32*i +: 32] = laneQ[i][0].a;
               reqB[32*i +: 32] = laneQ[i][0].b;
               reqStb[i]        = 1'b1;
            end
         end
      end
   end

   // Handshakes seen here complete on the next posedge; accepted ops feed the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < N; i++) begin
            if (reqStb[i] && reqAck[i]) begin
               reqDone[i] = 1'b1;
               if (laneQ[i].size() > 0) begin
                  accOp = laneQ[i].pop_front();
                  expE.lane = i;
                  expE.z    = accOp.z;
                  sb.push_back(expE);
                  acceptCount++;
               end
            end
            if (respStb[i] && respAck[i]) begin
               servedCount++;
               servedLanes.push_back(i);
               checkOutput("resp_stb onehot", 32'(respStb), 32'(1 << i));
               if (sb.size() == 0) begin
                  total++;
                  bad++;
                  $display("[TB] FAIL unexpected response: lane %0d z %h with nothing outstanding", i, respZ);
               end else begin
                  expE = sb.pop_front();
                  checkOutput("resp lane", 32'(i), 32'(expE.lane));
                  checkOutput("resp_z", respZ, expE.z);
               end
            end
         end
      end
   end

   task automatic applyStimulus(input int lane, input logic [31:0] a, input logic [31:0] b, input logic [31:0] z);
      op_t o;
      o.a = a;
      o.b = b;
      o.z = z;
      laneQ[lane].push_back(o);
   endtask

   task automatic resetDut();
      rst = 1'b1;
      for (int i = 0; i < N; i++) laneQ[i].delete();
      sb.delete();
      servedLanes.delete();
      reqStb  = '0;
      reqDone = '0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
   endtask

   task automatic waitResp(input int target, input int budget, input string name);
      int n = 0;
      while (servedCount < target && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput(name, 32'(servedCount >= target), 32'd1);
   endtask

   task automatic waitAccept(input int target, input int budget, input string name);
      int n = 0;
      while (acceptCount < target && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput(name, 32'(acceptCount >= target), 32'd1);
   endtask

   function automatic int laneAt(input int k);
      if (servedLanes.size() > k) return servedLanes[k];
      return -1;
   endfunction

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          target;
      int          n;
      logic [N-1:0] stbRef;
      logic [31:0] zRef;
      logic        stableStb;
      logic        stableZ;
      logic        noGrant;
      logic        sawAck;

      rst = 1'b1;
      reqA = '0;
      reqB = '0;
      reqStb = '0;
      reqDone = '0;
      holdAck = 1'b0;
      stubHoldZ = 1'b0;

      vecs[0] = '{0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000};
      vecs[1] = '{1, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
      vecs[2] = '{2, 32'h4000_0000, 32'h3F00_0000, 32'h3F80_0000};
      vecs[3] = '{3, 32'hC000_0000, 32'h4080_0000, 32'hC100_0000};
      vecs[4] = '{2, 32'h4040_0000, 32'h4040_0000, 32'h4110_0000};
      vecs[5] = '{0, 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000};

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      $display("[TB] reset state");
      @(negedge clk);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset req_ack", 32'(reqAck), 32'd0);
      checkOutput("reset resp_stb", 32'(respStb), 32'd0);
      checkOutput("reset mul_a_stb", 32'(mulAStb), 32'd0);
      checkOutput("reset mul_b_stb", 32'(mulBStb), 32'd0);
      checkOutput("reset mul_z_ack", 32'(mulZAck), 32'd0);
      checkOutput("reset err", 32'(err), 32'd0);
      checkOutput("reset resp_z", respZ, 32'd0);
      checkOutput("reset mul_a", mulA, 32'd0);
      checkOutput("reset mul_b", mulB, 32'd0);
      @(posedge clk);
      #1;

      $display("[TB] single-lane vectors");
      for (int v = 0; v < 6; v++) begin
         applyStimulus(vecs[v].lane, vecs[v].a, vecs[v].b, vecs[v].z);
         target = servedCount + 1;
         waitResp(target, 200, "vector response");
         checkOutput("vector served lane", 32'(laneAt(servedLanes.size() - 1)), 32'(vecs[v].lane));
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("resp_z holds in idle", respZ, 32'h4040_0000);
      checkOutput("idle busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;

      $display("[TB] four lanes at once");
      resetDut();
      for (int i = 0; i < N; i++) applyStimulus(i, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000);
      waitResp(servedCount + 4, 600, "four-lane responses");
      for (int k = 0; k < N; k++) checkOutput("four-lane grant order", 32'(laneAt(k)), 32'(k));

      $display("[TB] fairness");
      resetDut();
      target = acceptCount + 1;
      applyStimulus(2, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
      applyStimulus(2, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
      waitAccept(target, 100, "lane 2 first accept");
      applyStimulus(1, 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000);
      waitResp(servedCount + 3, 600, "fairness responses");
      checkOutput("fairness order 0", 32'(laneAt(0)), 32'd2);
      checkOutput("fairness order 1", 32'(laneAt(1)), 32'd1);
      checkOutput("fairness order 2", 32'(laneAt(2)), 32'd2);

      $display("[TB] reset during SEND_B");
      resetDut();
      applyStimulus(0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
      n = 0;
      while (!mulBStb && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("reached SEND_B", 32'(mulBStb), 32'd1);
      rst = 1'b1;
      for (int i = 0; i < N; i++) laneQ[i].delete();
      sb.delete();
      reqStb = '0;
      reqDone = '0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("mid-op reset busy", 32'(busy), 32'd0);
      checkOutput("mid-op reset req_ack", 32'(reqAck), 32'd0);
      checkOutput("mid-op reset resp_stb", 32'(respStb), 32'd0);
      checkOutput("mid-op reset mul_a_stb", 32'(mulAStb), 32'd0);
      checkOutput("mid-op reset mul_b_stb", 32'(mulBStb), 32'd0);
      checkOutput("mid-op reset mul_z_ack", 32'(mulZAck), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(3, 32'hC000_0000, 32'h4080_0000, 32'hC100_0000);
      waitResp(servedCount + 1, 200, "post-reset lane 3 response");

      $display("[TB] held resp_ack");
      holdAck = 1'b1;
      applyStimulus(1, 32'h4040_0000, 32'h4040_0000, 32'h4110_0000);
      n = 0;
      while (respStb == '0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      applyStimulus(0, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000);
      stbRef = respStb;
      zRef = respZ;
      checkOutput("held resp_stb value", 32'(stbRef), 32'h2);
      checkOutput("held resp_z value", zRef, 32'h4110_0000);
      stableStb = 1'b1;
      stableZ = 1'b1;
      noGrant = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (respStb !== stbRef) stableStb = 1'b0;
         if (respZ !== zRef) stableZ = 1'b0;
         if (reqAck !== '0 || busy !== 1'b1) noGrant = 1'b0;
      end
      checkOutput("held resp_stb stable", 32'(stableStb), 32'd1);
      checkOutput("held resp_z stable", 32'(stableZ), 32'd1);
      checkOutput("held no new grant", 32'(noGrant), 32'd1);
      @(posedge clk);
      #1;
      holdAck = 1'b0;
      waitResp(servedCount + 1, 20, "released response");
      @(negedge clk);
      checkOutput("idle after release", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      waitResp(servedCount + 1, 200, "pending lane 0 response");

`ifdef FPMUL_ARB_TIMEOUT_EN
      $display("[TB] multiplier timeout");
      resetDut();
      stubHoldZ = 1'b1;
      applyStimulus(2, 32'h4000_0000, 32'h4000_0000, 32'hFFC0_0000);
      waitResp(servedCount + 1, TIMEOUT + 200, "timeout response");
      @(negedge clk);
      checkOutput("timeout err", 32'(err), 32'd1);
      @(posedge clk);
      #1;
      applyStimulus(1, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
      sawAck = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (reqAck !== '0) sawAck = 1'b1;
      end
      checkOutput("blocked after timeout", 32'(sawAck), 32'd0);
      checkOutput("blocked busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      stubHoldZ = 1'b0;
      resetDut();
      @(negedge clk);
      checkOutput("err cleared by reset", 32'(err), 32'd0);
      @(posedge clk);
      #1;
`endif

      checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
